// File: rtl/twiddle_pkg.sv
// Shared types and constants for the runtime-loadable SDFT twiddle table.
package twiddle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    localparam int BYTE_W = 8;

    // Bytes per table entry: one real plus one imaginary coefficient.
    function automatic int calc_bpw(input int data_width);
        return (2 * data_width) / BYTE_W;
    endfunction

endpackage

// File: rtl/twiddle_ram.sv
// Simple dual-port coefficient store: one write port, one registered read-first read port.
module twiddle_ram #(
    parameter int addr_width = 4,
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata_real,
    input  logic [data_width-1:0] wdata_imaj,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata_real,
    output logic [data_width-1:0] rdata_imaj
);

    localparam int DEPTH = 2 ** addr_width;

    logic [data_width-1:0] mem_real [DEPTH];
    logic [data_width-1:0] mem_imaj [DEPTH];
    logic [data_width-1:0] rdata_real_q, rdata_real_d;
    logic [data_width-1:0] rdata_imaj_q, rdata_imaj_d;

    // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_real[waddr] <= wdata_real;
            mem_imaj[waddr] <= wdata_imaj;
        end
    end

    // Sampling the array before the edge gives read-first behaviour on a same-address collision.
    always_comb begin
        rdata_real_d = mem_real[raddr];
        rdata_imaj_d = mem_imaj[raddr];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_real_q <= '0;
            rdata_imaj_q <= '0;
        end else begin
            rdata_real_q <= rdata_real_d;
            rdata_imaj_q <= rdata_imaj_d;
        end
    end

    assign rdata_real = rdata_real_q;
    assign rdata_imaj = rdata_imaj_q;

endmodule

// File: rtl/twiddle_loader.sv
// Loads twiddle coefficients from a byte stream into a table read by the SDFT core.
// Optional TWIDDLE_LOADER_CHECKSUM_EN adds a modulo-256 byte checksum (csum, csum_valid).
module twiddle_loader
    import twiddle_pkg::*;
#(
    parameter int addr_width = 4,
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [BYTE_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  loading,
    output logic                  load_done,
    input  logic [addr_width-1:0] addr,
    output logic [data_width-1:0] dout_real,
    output logic [data_width-1:0] dout_imaj
`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    ,
    output logic [BYTE_W-1:0]     csum,
    output logic                  csum_valid
`endif
);

    localparam int BPW     = calc_bpw(data_width);
    localparam int CNT_W   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int ASM_W   = (BPW - 1) * BYTE_W;
    localparam int ENTRY_W = 2 * data_width;

    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BPW - 1);
    localparam logic [addr_width-1:0] LAST_ADDR = '1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [addr_width-1:0] wr_addr_q, wr_addr_d;
    logic [ASM_W-1:0]      asm_q, asm_d;
    logic                  we;
    logic [ENTRY_W-1:0]    entry;

    // The final byte completes the entry directly, so the write lands on its acceptance edge.
    assign entry = {asm_q, in_data};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wr_addr_d  = wr_addr_q;
        asm_d      = asm_q;
        we         = 1'b0;
        in_ready   = 1'b0;
        loading    = 1'b0;
        load_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d    = LOAD;
                    byte_cnt_d = '0;
                    wr_addr_d  = '0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                loading  = 1'b1;
                // A restart wins over a byte offered in the same cycle.
                if (load_start) begin
                    byte_cnt_d = '0;
                    wr_addr_d  = '0;
                end else if (in_valid) begin
                    asm_d = ASM_W'({asm_q, in_data});
                    if (byte_cnt_q == LAST_BYTE) begin
                        we         = 1'b1;
                        byte_cnt_d = '0;
                        wr_addr_d  = wr_addr_q + 1'b1;
                        if (wr_addr_q == LAST_ADDR) begin
                            state_d = DONE;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                load_done = 1'b1;
                if (load_start) begin
                    state_d    = LOAD;
                    byte_cnt_d = '0;
                    wr_addr_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            wr_addr_q  <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            wr_addr_q  <= wr_addr_d;
            asm_q      <= asm_d;
        end
    end

    twiddle_ram #(
        .addr_width (addr_width),
        .data_width (data_width)
    ) u_ram (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .waddr      (wr_addr_q),
        .wdata_real (entry[ENTRY_W-1 -: data_width]),
        .wdata_imaj (entry[data_width-1:0]),
        .raddr      (addr),
        .rdata_real (dout_real),
        .rdata_imaj (dout_imaj)
    );

`ifdef TWIDDLE_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (load_start) begin
            csum_d = '0;
        end else if (state_q == LOAD && in_valid) begin
            csum_d = csum_q + in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum       = csum_q;
    assign csum_valid = (state_q == DONE);
`endif

endmodule
